// File: rtl/l1_way_mem.sv
// Multi-way L1 data array built from byte-wide single-port slices, with an init sweep after reset/INIT_REQ.
// Optional feature: define L1_MEM_PARITY_EN to store an even-parity bit per byte and report PERR.

module sram_sp #(
   parameter int DW    = 8,
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= d;
         else    q         <= mem[addr];
      end
   end
endmodule

module l1_way_mem #(
   parameter int               WIDTH    = 32,
   parameter int               DEPTH    = 1024,
   parameter int               WAYS     = 4,
   parameter logic [WIDTH-1:0] INIT_VAL = '0,
   localparam int              AW       = $clog2(DEPTH),
   localparam int              WW       = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    INIT_REQ,
   input  logic                    EN,
   input  logic                    WE,
   input  logic [WW-1:0]           WAY_IDX,
   input  logic [AW-1:0]           ADDR,
   input  logic [WIDTH/8-1:0]      BE,
   input  logic [WIDTH-1:0]        WDATA,
   output logic [WAYS*WIDTH-1:0]   RDATA,
   output logic                    RVALID,
   output logic                    READY,
   output logic [WAYS-1:0]         PERR
);
   localparam int NB = WIDTH / 8;
`ifdef L1_MEM_PARITY_EN
   localparam int SW = 9;
`else
   localparam int SW = 8;
`endif

   typedef enum logic {S_INIT, S_RUN} state_t;
   typedef struct packed {
      logic          en;
      logic          we;
      logic [AW-1:0] addr;
      logic [SW-1:0] data;
   } slice_req_t;

   state_t                          state;
   logic [AW-1:0]                   cnt;
   logic                            rd_acc;
   logic [WAYS-1:0][NB-1:0][SW-1:0] q;

   function automatic logic [SW-1:0] enc(input logic [7:0] b);
`ifdef L1_MEM_PARITY_EN
      return {^b, b};
`else
      return b;
`endif
   endfunction

   assign rd_acc = EN & ~WE & READY;

   // READY is the registered image of state==S_RUN; the access seen with INIT_REQ still completes.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= S_INIT;
         cnt    <= '0;
         READY  <= 1'b0;
         RVALID <= 1'b0;
      end else begin
         RVALID <= rd_acc;
         case (state)
            S_INIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == AW'(DEPTH - 1)) begin
                  state <= S_RUN;
                  READY <= 1'b1;
               end
            end
            S_RUN: begin
               if (INIT_REQ) begin
                  state <= S_INIT;
                  cnt   <= '0;
                  READY <= 1'b0;
               end
            end
         endcase
      end
   end

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic [NB-1:0] bad;

      for (genvar b = 0; b < NB; b++) begin : g_byte
         slice_req_t req;

         // A WAY_IDX beyond the last way never matches, so such writes fall away.
         always_comb begin
            req.en   = EN & READY & (~WE | ((WAY_IDX == WW'(w)) & BE[b]));
            req.we   = WE;
            req.addr = ADDR;
            req.data = enc(WDATA[b*8 +: 8]);
            if (state == S_INIT) begin
               req.en   = 1'b1;
               req.we   = 1'b1;
               req.addr = cnt;
               req.data = enc(INIT_VAL[b*8 +: 8]);
            end
         end

         sram_sp #(.DW(SW), .DEPTH(DEPTH), .AW(AW)) u_slice (
            .clk  (CLK),
            .en   (req.en),
            .we   (req.we),
            .addr (req.addr),
            .d    (req.data),
            .q    (q[w][b])
         );

         assign RDATA[w*WIDTH + b*8 +: 8] = q[w][b][7:0];
         assign bad[b] = ^q[w][b];
      end

`ifdef L1_MEM_PARITY_EN
      assign PERR[w] = RVALID & (|bad);
`else
      assign PERR[w] = 1'b0;
`endif
   end
endmodule

// File: tb/tb_l1_way_mem.sv
// Directed bench for l1_way_mem: vector table plus sweep, re-init, mid-sweep reset and streaming sequences.
module tb_l1_way_mem;
   localparam logic [31:0] IV = 32'hA5A5A5A5;

   logic         CLK = 1'b0, RST_N = 1'b0, INIT_REQ = 1'b0, EN = 1'b0, WE = 1'b0;
   logic [1:0]   WAY_IDX = '0;
   logic [3:0]   ADDR = '0, BE = '0;
   logic [31:0]  WDATA = '0;
   logic [127:0] RDATA;
   logic         RVALID, READY;
   logic [3:0]   PERR;
   logic [95:0]  rdata3;
   logic         rvalid3, ready3;
   logic [2:0]   perr3;
   int           n_cmp = 0, n_bad = 0;

   always #5 CLK = ~CLK;

   l1_way_mem #(.WIDTH(32), .DEPTH(16), .WAYS(4), .INIT_VAL(IV)) dut (
      .CLK(CLK), .RST_N(RST_N), .INIT_REQ(INIT_REQ), .EN(EN), .WE(WE), .WAY_IDX(WAY_IDX),
      .ADDR(ADDR), .BE(BE), .WDATA(WDATA), .RDATA(RDATA), .RVALID(RVALID), .READY(READY), .PERR(PERR));

   // Three ways on a two-bit WAY_IDX: way index 3 is out of range here.
   l1_way_mem #(.WIDTH(32), .DEPTH(16), .WAYS(3), .INIT_VAL(IV)) dut3 (
      .CLK(CLK), .RST_N(RST_N), .INIT_REQ(INIT_REQ), .EN(EN), .WE(WE), .WAY_IDX(WAY_IDX),
      .ADDR(ADDR), .BE(BE), .WDATA(WDATA), .RDATA(rdata3), .RVALID(rvalid3), .READY(ready3), .PERR(perr3));

   typedef struct {
      logic         we;
      logic [1:0]   way;
      logic [3:0]   addr;
      logic [3:0]   be;
      logic [31:0]  wdata;
      logic [127:0] exp;
   } vec_t;
   vec_t tbl [13];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic access(input logic we, input logic [1:0] way, input logic [3:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
      EN = 1'b1; WE = we; WAY_IDX = way; ADDR = a; BE = be; WDATA = wd;
      tick();
      EN = 1'b0; WE = 1'b0;
   endtask

   task automatic write_all(input logic [31:0] wd);
      for (int a = 0; a < 16; a++)
         for (int w = 0; w < 4; w++) access(1'b1, 2'(w), 4'(a), 4'hF, wd);
   endtask

   task automatic sweep_ready(input string tag);
      for (int k = 1; k <= 16; k++) begin
         tick();
         check($sformatf("%s_ready_k%0d", tag, k), 128'(READY), 128'(k == 16));
      end
   endtask

   task automatic read_all_init(input string tag);
      for (int a = 0; a < 16; a++) begin
         EN = 1'b1; WE = 1'b0; ADDR = 4'(a);
         tick();
         check($sformatf("%s_rvalid_a%0d", tag, a), 128'(RVALID), 128'(1));
         check($sformatf("%s_data_a%0d", tag, a), RDATA, {4{IV}});
      end
      EN = 1'b0;
      tick();
      check($sformatf("%s_rvalid_end", tag), 128'(RVALID), 128'(0));
   endtask

   function automatic logic [31:0] pat(input int w, input int a);
      return {8'(w), 8'(a), 8'hC3, 8'(w * 16 + a)};
   endfunction

   initial begin
      tbl[0]  = '{1'b0, 2'd0, 4'd5,  4'h0, 32'h0,        {4{IV}}};
      tbl[1]  = '{1'b1, 2'd2, 4'd3,  4'h5, 32'hDEADBEEF, 128'h0};
      tbl[2]  = '{1'b0, 2'd0, 4'd3,  4'h0, 32'h0,        {IV, 32'hA5ADA5EF, IV, IV}};
      tbl[3]  = '{1'b1, 2'd0, 4'd3,  4'hF, 32'h11223344, 128'h0};
      tbl[4]  = '{1'b1, 2'd3, 4'd3,  4'h8, 32'h55667788, 128'h0};
      tbl[5]  = '{1'b0, 2'd0, 4'd3,  4'h0, 32'h0,        {32'h55A5A5A5, 32'hA5ADA5EF, IV, 32'h11223344}};
      tbl[6]  = '{1'b1, 2'd1, 4'd15, 4'h3, 32'hCAFEF00D, 128'h0};
      tbl[7]  = '{1'b0, 2'd0, 4'd15, 4'h0, 32'h0,        {IV, IV, 32'hA5A5F00D, IV}};
      tbl[8]  = '{1'b0, 2'd0, 4'd0,  4'h0, 32'h0,        {4{IV}}};
      tbl[9]  = '{1'b1, 2'd1, 4'd0,  4'h6, 32'h01020304, 128'h0};
      tbl[10] = '{1'b0, 2'd0, 4'd0,  4'h0, 32'h0,        {IV, IV, 32'hA50203A5, IV}};
      tbl[11] = '{1'b1, 2'd2, 4'd0,  4'h0, 32'hFFFFFFFF, 128'h0};
      tbl[12] = '{1'b0, 2'd0, 4'd0,  4'h0, 32'h0,        {IV, IV, 32'hA50203A5, IV}};

      // Reset state, then the sweep after release.
      repeat (2) @(posedge CLK);
      #1;
      check("rst_ready", 128'(READY), 128'(0));
      check("rst_rvalid", 128'(RVALID), 128'(0));
      check("rst_perr", 128'(PERR), 128'(0));
      RST_N = 1'b1;
      sweep_ready("init");
      check("init_ready3", 128'(ready3), 128'(1));

      for (int i = 0; i < 13; i++) begin
         access(tbl[i].we, tbl[i].way, tbl[i].addr, tbl[i].be, tbl[i].wdata);
         if (tbl[i].we) begin
            check($sformatf("vec%0d_rvalid", i), 128'(RVALID), 128'(0));
         end else begin
            check($sformatf("vec%0d_rvalid", i), 128'(RVALID), 128'(1));
            check($sformatf("vec%0d_rdata", i), RDATA, tbl[i].exp);
            check($sformatf("vec%0d_perr", i), 128'(PERR), 128'(0));
         end
      end

      // Streaming reads after distinct writes; dut3 must ignore every way-3 write.
      for (int a = 0; a < 16; a++)
         for (int w = 0; w < 4; w++) access(1'b1, 2'(w), 4'(a), 4'hF, pat(w, a));
      for (int a = 0; a < 16; a++) begin
         EN = 1'b1; WE = 1'b0; ADDR = 4'(a);
         tick();
         check($sformatf("stream_rvalid_a%0d", a), 128'(RVALID), 128'(1));
         check($sformatf("stream_data_a%0d", a), RDATA, {pat(3, a), pat(2, a), pat(1, a), pat(0, a)});
         check($sformatf("stream_oor_a%0d", a), 128'(rdata3), 128'({pat(2, a), pat(1, a), pat(0, a)}));
         check($sformatf("stream_perr3_a%0d", a), 128'(perr3), 128'(0));
      end
      EN = 1'b0;
      tick();
      check("stream_rvalid_end", 128'(RVALID), 128'(0));
      check("stream_rvalid3_end", 128'(rvalid3), 128'(0));

      // Re-init: the read issued with INIT_REQ completes; accesses during the sweep are dropped.
      write_all(32'h12345678);
      EN = 1'b1; WE = 1'b0; ADDR = 4'd2; INIT_REQ = 1'b1;
      tick();
      EN = 1'b0; INIT_REQ = 1'b0;
      check("reinit_rd_rvalid", 128'(RVALID), 128'(1));
      check("reinit_rd_data", RDATA, {4{32'h12345678}});
      check("reinit_ready_low", 128'(READY), 128'(0));
      for (int k = 1; k <= 16; k++) begin
         EN = k[0]; WE = (k % 4 == 1); WAY_IDX = 2'd0; ADDR = 4'(k - 1); BE = 4'hF; WDATA = 32'hFFFFFFFF;
         tick();
         check($sformatf("reinit_drop_rvalid_k%0d", k), 128'(RVALID), 128'(0));
         check($sformatf("reinit_ready_k%0d", k), 128'(READY), 128'(k == 16));
      end
      EN = 1'b0; WE = 1'b0;
      read_all_init("reinit");

      // Reset at cnt=7 restarts a full sweep.
      write_all(32'h12345678);
      INIT_REQ = 1'b1;
      tick();
      INIT_REQ = 1'b0;
      repeat (7) tick();
      RST_N = 1'b0;
      #1;
      check("midrst_ready", 128'(READY), 128'(0));
      check("midrst_rvalid", 128'(RVALID), 128'(0));
      tick();
      tick();
      RST_N = 1'b1;
      sweep_ready("midrst");
      read_all_init("midrst");

      // Parity: corrupt one stored bit of way 1, addr 4.
`ifdef L1_MEM_PARITY_EN
      dut.g_way[1].g_byte[0].u_slice.mem[4][0] = ~dut.g_way[1].g_byte[0].u_slice.mem[4][0];
`endif
      access(1'b0, 2'd0, 4'd4, 4'h0, 32'h0);
      check("par_rvalid", 128'(RVALID), 128'(1));
`ifdef L1_MEM_PARITY_EN
      check("par_perr", 128'(PERR), 128'(4'b0010));
`else
      check("par_perr", 128'(PERR), 128'(4'b0000));
`endif
      tick();
      check("par_perr_idle", 128'(PERR), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
